// File: rtl/dmem_arb_pkg.sv
// Shared types and sizes for the two-port data-memory arbiter.
// Holds the FSM state encoding, port-id type and latency counter type.
package dmem_arb_pkg;

    localparam int NPORTS = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [$clog2(NPORTS)-1:0] port_id_t;
    typedef logic [CNT_W-1:0]          cnt_t;

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin picker: under contention the port not granted last wins.
// Purely combinational; the last-grant register lives in the parent.
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic              last_gnt,
    output logic              gnt_valid,
    output logic              gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (req[0] && req[1]) begin
            gnt_id = ~last_gnt;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer between instruction fetch (port 0) and load/store (port 1)
// in front of a single-port data memory with a fixed read latency.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam cnt_t LAT_LOAD = cnt_t'(MEM_LAT - 1);

    state_e        state_q, state_d;
    port_id_t      port_q, port_d;
    port_id_t      last_q, last_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    cnt_t          cnt_q, cnt_d;

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic              rdata_cap;
    logic [NPORTS-1:0] done_vec;
    logic [NPORTS-1:0] err_vec;

    dmem_arb_rr u_rr (
        .req       ({req1, req0}),
        .last_gnt  (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign sel_we    = gnt_id ? we1    : we0;
    assign sel_addr  = gnt_id ? addr1  : addr0;
    assign sel_wdata = gnt_id ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            port_q  <= '0;
            last_q  <= port_id_t'(1);
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        last_d  = last_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    port_d  = gnt_id;
                    last_d  = gnt_id;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = (sel_addr[1:0] != 2'b00);
                    // Misaligned accesses skip the memory entirely.
                    state_d = (sel_addr[1:0] != 2'b00) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes and done decode straight from state so reset clears them at once.
    assign mem_read  = (state_q == ST_ISSUE) && !we_q;
    assign mem_write = (state_q == ST_ISSUE) &&  we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata_cap = (state_q == ST_WAIT) && (cnt_q == '0) && !we_q;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        logic [DW-1:0] rdata_q;

        assign done_vec[gi] = (state_q == ST_DONE) && (port_q == port_id_t'(gi));
        assign err_vec[gi]  = done_vec[gi] && err_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (rdata_cap && (port_q == port_id_t'(gi))) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign done0  = done_vec[0];
    assign done1  = done_vec[1];
    assign err0   = err_vec[0];
    assign err1   = err_vec[1];
    assign rdata0 = g_port[0].rdata_q;
    assign rdata1 = g_port[1].rdata_q;

endmodule
